// File: rtl/rr_arbiter.sv
// Round-robin arbiter: rotating-pointer pick in IDLE, registered one-hot grant
// held until done, owner withdrawal, or the hold limit expires.
//
// state | meaning
// IDLE  | no owner; arbitrate among req_i starting at ptr
// GRANT | one requester owns the resource; watch done/abort/hold limit
`timescale 1ns/1ps
module rr_arbiter #(
  parameter int N        = 8,
  parameter int MAX_HOLD = 16,
  parameter int IDX_W    = $clog2(N)
) (
  input  logic             clk_i,
  input  logic             arstn_i,
  input  logic [N-1:0]     req_i,
  input  logic             done_i,
  output logic [N-1:0]     gnt_o,
  output logic             gnt_val_o,
  output logic [IDX_W-1:0] gnt_idx_o,
  output logic             timeout_o
);

  localparam int CNT_W = $clog2(MAX_HOLD) + 1;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [N-1:0]     gnt_q, gnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             to_q, to_d;

  logic [N-1:0]     ptr_mask;
  logic [N-1:0]     masked;
  logic [IDX_W-1:0] hi_win, lo_win, winner;
  logic [IDX_W-1:0] ptr_next;
  logic             owner_req;
  logic             hold_hit;

  // Requests at or above ptr win first; otherwise wrap to the lowest request.
  always_comb begin
    ptr_mask = '0;
    hi_win   = '0;
    lo_win   = '0;
    for (int i = 0; i < N; i++) begin
      ptr_mask[i] = (IDX_W'(i) >= ptr_q);
    end
    masked = req_i & ptr_mask;
    for (int i = N - 1; i >= 0; i--) begin
      if (masked[i]) hi_win = IDX_W'(i);
      if (req_i[i])  lo_win = IDX_W'(i);
    end
    winner = (|masked) ? hi_win : lo_win;
  end

  assign ptr_next  = (idx_q == IDX_W'(N - 1)) ? '0 : idx_q + IDX_W'(1);
  assign owner_req = req_i[idx_q];
  assign hold_hit  = (MAX_HOLD != 0) && (cnt_q == CNT_W'(MAX_HOLD - 1));

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    to_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req_i) begin
          gnt_d   = {{(N-1){1'b0}}, 1'b1} << winner;
          idx_d   = winner;
          cnt_d   = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (done_i || !owner_req || hold_hit) begin
          gnt_d   = '0;
          ptr_d   = ptr_next;
          state_d = IDLE;
          // Timeout is only reported when it is the sole reason for release.
          to_d    = !done_i && owner_req;
        end else if (MAX_HOLD != 0) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      gnt_q   <= '0;
      cnt_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
    end
  end

  assign gnt_o     = gnt_q;
  assign gnt_val_o = |gnt_q;
  assign gnt_idx_o = idx_q;
  assign timeout_o = to_q;

endmodule
